// File: rtl/zero_scan_if.sv
// zero_scan_if: handshake bundle for zero_scan_unit.
//   in_valid/in_ready/in_data        : word to scan (producer -> scanner)
//   out_valid/out_ready              : result handshake (scanner -> consumer)
//   out_zero                         : scanned word was all zero
//   out_index                        : lowest set bit, or WIDTH when all zero
// master = producer/consumer side, slave = the scanner.
`timescale 1ns/1ps
interface zero_scan_if #(
    parameter int WIDTH = 8,
    parameter int IW    = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_zero;
    logic [IW-1:0]    out_index;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_zero, out_index
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_zero, out_index
    );
endinterface

// File: rtl/zero_scan_unit.sv
// zero_scan_unit: sequential all-zero detector and lowest-set-bit locator.
// A word is accepted in IDLE, scanned LANES bits per clock from bit 0 up,
// and the result is held in DONE until consumed.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : zero_scan_if.slave (input word / result handshakes)
//   cnt_clr     : synchronous clear of zero_cnt (wins over increment)
//   zero_cnt    : saturating count of consumed all-zero results
// Parameters: WIDTH >= 1, LANES must divide WIDTH, EARLY_EXIT stops at the
// first set bit, CNT_W is the counter width.
`timescale 1ns/1ps

// One bit of the per-chunk priority chain: flags the bit if it is set and
// no lower bit of the chunk is set.
module zero_scan_lane (
    input  logic bit_in,
    input  logic lower_any,
    output logic first,
    output logic any_out
);
    assign first   = bit_in & ~lower_any;
    assign any_out = bit_in | lower_any;
endmodule

module zero_scan_unit #(
    parameter int WIDTH      = 8,
    parameter int LANES      = 1,
    parameter int EARLY_EXIT = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    zero_scan_if.slave       bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] zero_cnt
);
    localparam int CHUNKS = WIDTH / LANES;
    localparam int PW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IW     = $clog2(WIDTH + 1);
    localparam logic [PW-1:0] LAST = PW'(CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [WIDTH-1:0] word;
    logic             found;
    logic [IW-1:0]    idx;

    logic [LANES-1:0] chunk;
    logic [LANES-1:0] first;
    logic [LANES:0]   carry;
    logic             hit;
    logic [LW-1:0]    lo;
    logic [IW-1:0]    cand;
    logic             stop;

    // Current chunk, bits [ptr*LANES +: LANES] of the captured word.
    assign chunk    = LANES'(word >> (int'(ptr) * LANES));
    assign carry[0] = 1'b0;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        zero_scan_lane u_lane (
            .bit_in    (chunk[l]),
            .lower_any (carry[l]),
            .first     (first[l]),
            .any_out   (carry[l+1])
        );
    end

    assign hit = carry[LANES];

    // first[] is one-hot (or zero), so OR-ing lane numbers encodes it.
    always_comb begin
        lo = '0;
        for (int l = 0; l < LANES; l++)
            if (first[l]) lo = lo | LW'(l);
    end

    assign cand = IW'(int'(ptr) * LANES + int'(lo));
    assign stop = (ptr == LAST) || ((EARLY_EXIT != 0) && hit);

    assign bus.in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            word          <= '0;
            found         <= 1'b0;
            idx           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_zero  <= 1'b0;
            bus.out_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        word  <= bus.in_data;
                        ptr   <= '0;
                        found <= 1'b0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    // Only the first hit is recorded; later chunks cannot
                    // overwrite it when scanning the full word.
                    if (hit && !found) begin
                        idx   <= cand;
                        found <= 1'b1;
                    end
                    if (stop) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.out_zero  <= ~(found | hit);
                        bus.out_index <= found ? idx : (hit ? cand : IW'(WIDTH));
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            zero_cnt <= '0;
        else if (cnt_clr)
            zero_cnt <= '0;
        else if (bus.out_valid && bus.out_ready && bus.out_zero &&
                 zero_cnt != {CNT_W{1'b1}})
            zero_cnt <= zero_cnt + 1'b1;
    end
endmodule
